// File: rtl/sa_ram_rws_param.sv
// sa_ram_rws_param: simple-dual-port RAM with byte enables, 1/2-cycle read latency, write-to-read bypass and sticky error flags
module sa_ram_rws_param #(
  parameter int WIDTH   = 128,
  parameter int DEPTH   = 128,
  parameter int AW      = 7,
  parameter int OUT_REG = 0,
  parameter int BYPASS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      ra,
  input  logic               re,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_vld,
  input  logic [AW-1:0]      wa,
  input  logic               we,
  input  logic [WIDTH/8-1:0] wbe,
  input  logic [WIDTH-1:0]   di,
  input  logic [31:0]        pwrbus_ram_pd,
  output logic               col_err,
  output logic               oob_err
);
  localparam int NB = WIDTH / 8;
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);
  if (WIDTH % 8 != 0 || (2 ** AW) < DEPTH) begin : g_param_err
    $error("sa_ram_rws_param: WIDTH must be a multiple of 8 and 2**AW >= DEPTH");
  end
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] w_mask, w_old, w_rd_word, r_d1;
  logic             w_ra_ok, w_wa_ok, w_col, r_v1, w_unused;
  assign w_unused = ^pwrbus_ram_pd;
  for (genvar b = 0; b < NB; b++) begin : g_mask
    assign w_mask[8*b +: 8] = {8{wbe[b]}};
  end
  assign w_ra_ok   = {1'b0, ra} < DEPTH_V;
  assign w_wa_ok   = {1'b0, wa} < DEPTH_V;
  assign w_col     = re && we && w_ra_ok && (ra == wa);
  assign w_old     = w_ra_ok ? r_mem[ra] : '0;
  assign w_rd_word = (BYPASS != 0 && w_col) ? ((w_old & ~w_mask) | (di & w_mask)) : w_old;
  // memory is deliberately outside the reset domain so writes land even during rst
  always_ff @(posedge clk) begin
    if (we && w_wa_ok)
      for (int i = 0; i < NB; i++)
        if (wbe[i]) r_mem[wa][8*i +: 8] <= di[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_d1    <= '0;
      col_err <= 1'b0;
      oob_err <= 1'b0;
    end else begin
      r_v1 <= re;
      if (re) r_d1 <= w_rd_word;
      if (w_col && BYPASS == 0) col_err <= 1'b1;
      if ((re && !w_ra_ok) || (we && !w_wa_ok)) oob_err <= 1'b1;
    end
  end
  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] r_d2;
    logic             r_v2;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v2 <= 1'b0;
        r_d2 <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) r_d2 <= r_d1;
      end
    end
    assign dout     = r_d2;
    assign dout_vld = r_v2;
  end else begin : g_noreg
    assign dout     = r_d1;
    assign dout_vld = r_v1;
  end
endmodule

// File: tb/tb_sa_ram_rws_param.sv
// tb_sa_ram_rws_param: scoreboard bench driving a latency-1/bypass instance and a latency-2/no-bypass instance in lockstep
module tb_sa_ram_rws_param;
  logic        clk = 0, rst = 0, re = 0, we = 0;
  logic [6:0]  ra = 0, wa = 0;
  logic [3:0]  wbe = 0;
  logic [31:0] di = 0, pd = 0;
  logic [31:0] a_dout, b_dout;
  logic        a_vld, b_vld, a_col, b_col, a_oob, b_oob;
  typedef struct {logic [31:0] d; int due;} exp_t;
  exp_t        qa[$], qb[$];
  logic [31:0] ref_mem [100];
  int          cyc = 0, checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sa_ram_rws_param #(.WIDTH(32), .DEPTH(100), .AW(7), .OUT_REG(0), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(a_dout), .dout_vld(a_vld), .wa(wa), .we(we),
    .wbe(wbe), .di(di), .pwrbus_ram_pd(pd), .col_err(a_col), .oob_err(a_oob));
  sa_ram_rws_param #(.WIDTH(32), .DEPTH(100), .AW(7), .OUT_REG(1), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(b_dout), .dout_vld(b_vld), .wa(wa), .we(we),
    .wbe(wbe), .di(di), .pwrbus_ram_pd(pd), .col_err(b_col), .oob_err(b_oob));

  function automatic logic [31:0] bmask(input logic [3:0] be);
    for (int i = 0; i < 4; i++) bmask[8*i +: 8] = {8{be[i]}};
  endfunction

  task automatic drive(input logic s_rst, input logic s_re, input logic [6:0] s_ra, input logic s_we,
                       input logic [6:0] s_wa, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] m, old;
    @(posedge clk); #1;
    rst = s_rst; re = s_re; ra = s_ra; we = s_we; wa = s_wa; wbe = be; di = d;
    m   = bmask(be);
    old = (s_ra < 100) ? ref_mem[s_ra] : 32'h0;
    if (s_re && !s_rst) begin
      qa.push_back('{(s_we && s_wa == s_ra && s_ra < 100) ? ((old & ~m) | (d & m)) : old, cyc + 1});
      qb.push_back('{old, cyc + 2});
    end
    if (s_we && s_wa < 100) ref_mem[s_wa] = (ref_mem[s_wa] & ~m) | (d & m);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() != 0 && qa[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL sb_a_missing: no dout_vld by cycle %0d, expected %h", qa[0].due, qa[0].d);
        void'(qa.pop_front());
      end
      if (qb.size() != 0 && qb[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL sb_b_missing: no dout_vld by cycle %0d, expected %h", qb[0].due, qb[0].d);
        void'(qb.pop_front());
      end
      if (a_vld) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL sb_a_unexpected: dout_vld with dout=%h at cycle %0d, expected none", a_dout, cyc);
        end else begin
          e = qa.pop_front();
          if (a_dout !== e.d || cyc !== e.due) begin
            errors++;
            $display("FAIL sb_a: got %h at cycle %0d, expected %h at cycle %0d", a_dout, cyc, e.d, e.due);
          end
        end
      end
      if (b_vld) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL sb_b_unexpected: dout_vld with dout=%h at cycle %0d, expected none", b_dout, cyc);
        end else begin
          e = qb.pop_front();
          if (b_dout !== e.d || cyc !== e.due) begin
            errors++;
            $display("FAIL sb_b: got %h at cycle %0d, expected %h at cycle %0d", b_dout, cyc, e.d, e.due);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(1);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 1, 3, 4'hf, 32'hA5A5A5A5);
    idle(1);
    @(negedge clk);
    checks++;
    if ({a_dout, a_vld, a_col, a_oob} !== 35'h0) begin
      errors++;
      $display("FAIL reset_a: got dout=%h vld=%b col=%b oob=%b, expected all 0", a_dout, a_vld, a_col, a_oob);
    end
    checks++;
    if ({b_dout, b_vld, b_col, b_oob} !== 35'h0) begin
      errors++;
      $display("FAIL reset_b: got dout=%h vld=%b col=%b oob=%b, expected all 0", b_dout, b_vld, b_col, b_oob);
    end
  endtask

  task automatic test_latency();
    drive(0, 1, 3, 0, 0, 0, 0);
    idle(3);
  endtask

  task automatic test_byte_en();
    drive(0, 0, 0, 1, 5, 4'hf, 32'hFFFFFFFF);
    drive(0, 0, 0, 1, 5, 4'h1, 32'h0);
    drive(0, 1, 5, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5, 4'h0, 32'h0);
    drive(0, 1, 5, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5, 4'h6, 32'h12345678);
    drive(0, 1, 5, 0, 0, 0, 0);
    idle(3);
  endtask

  task automatic test_collision();
    drive(0, 0, 0, 1, 7, 4'hf, 32'h11111111);
    drive(0, 1, 7, 1, 7, 4'hf, 32'h22222222);
    idle(1);
    @(negedge clk);
    checks++;
    if (a_col !== 1'b0) begin
      errors++;
      $display("FAIL col_a: got col_err=%b, expected 0", a_col);
    end
    checks++;
    if (b_col !== 1'b1) begin
      errors++;
      $display("FAIL col_b: got col_err=%b, expected 1", b_col);
    end
    drive(0, 1, 8, 1, 9, 4'hf, 32'h33333333);
    idle(3);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 7'(i), 4'hf, 32'h01010101 * (i + 1) ^ 32'h5A00_0000);
    for (int i = 0; i < 10; i++) drive(0, 1, 7'(i), 0, 0, 0, 0);
    idle(4);
    @(negedge clk);
    checks++;
    if (a_dout !== ref_mem[9]) begin
      errors++;
      $display("FAIL hold_a: got %h, expected %h", a_dout, ref_mem[9]);
    end
    checks++;
    if (b_dout !== ref_mem[9]) begin
      errors++;
      $display("FAIL hold_b: got %h, expected %h", b_dout, ref_mem[9]);
    end
    checks++;
    if (b_col !== 1'b1) begin
      errors++;
      $display("FAIL col_sticky: got col_err=%b, expected 1", b_col);
    end
  endtask

  task automatic test_oob();
    drive(0, 0, 0, 1, 20, 4'hf, 32'h20202020);
    drive(0, 0, 0, 1, 56, 4'hf, 32'h56565656);
    do_reset();
    @(negedge clk);
    checks++;
    if ({a_oob, b_oob, b_col} !== 3'b000) begin
      errors++;
      $display("FAIL flags_cleared: got oob_a=%b oob_b=%b col_b=%b, expected 000", a_oob, b_oob, b_col);
    end
    drive(0, 1, 120, 0, 0, 0, 0);
    idle(1);
    @(negedge clk);
    checks++;
    if ({a_oob, b_oob} !== 2'b11) begin
      errors++;
      $display("FAIL oob_read: got oob_a=%b oob_b=%b, expected 11", a_oob, b_oob);
    end
    idle(2);
    do_reset();
    drive(0, 0, 0, 1, 120, 4'hf, 32'hDEADBEEF);
    idle(1);
    @(negedge clk);
    checks++;
    if ({a_oob, b_oob} !== 2'b11) begin
      errors++;
      $display("FAIL oob_write: got oob_a=%b oob_b=%b, expected 11", a_oob, b_oob);
    end
    drive(0, 1, 20, 0, 0, 0, 0);
    drive(0, 1, 56, 0, 0, 0, 0);
    drive(0, 1, 120, 0, 0, 0, 0);
    idle(3);
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 3, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    qb.delete();
    idle(1);
    @(negedge clk);
    checks++;
    if ({b_vld, b_dout} !== 33'h0) begin
      errors++;
      $display("FAIL reset_mid_b: got vld=%b dout=%h, expected vld=0 dout=0", b_vld, b_dout);
    end
    checks++;
    if (a_dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_a: got dout=%h, expected 0", a_dout);
    end
    drive(0, 1, 3, 0, 0, 0, 0);
    idle(4);
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_latency();
    test_byte_en();
    test_collision();
    test_stream();
    test_oob();
    test_reset_mid();
    idle(3);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d reads outstanding, expected 0/0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sa_ram_rws_param.md
Name: sa_ram_rws_param

Overview:
- Parametrised simple-dual-port RAM model: one read port, one write port, single clock, for FPGA model builds of systolic-array buffers.
- Generalises the fixed 128x128 RAM models to arbitrary width and depth.
- Adds byte-enable writes, selectable read latency, same-address write-to-read bypass, a read-valid strobe, out-of-range address handling and sticky error flags.

Parameters:
WIDTH, 128, data width in bits; must be a multiple of 8.
DEPTH, 128, number of words; need not be a power of two.
AW, 7, address width; must satisfy 2**AW >= DEPTH.
OUT_REG, 0, 0 = read latency 1; 1 = an extra output register, read latency 2.
BYPASS, 1, 1 = same-cycle same-address read returns the newly written data; 0 = returns the old data and flags a collision.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous active-high reset.
ra  input  AW  read address.
re  input  1  read enable.
dout  output  WIDTH  read data.
dout_vld  output  1  one-cycle strobe; dout carries the data of a completed read.
wa  input  AW  write address.
we  input  1  write enable.
wbe  input  WIDTH/8  per-byte write enables; bit i covers di[8i+7:8i].
di  input  WIDTH  write data.
pwrbus_ram_pd  input  32  power-down bus; no functional effect; kept for interface compatibility.
col_err  output  1  sticky flag: a same-address collision occurred while BYPASS=0.
oob_err  output  1  sticky flag: an out-of-range access occurred (address >= DEPTH).

Behaviour:
- Reset (rst=1 at a clk edge):
  - dout, dout_vld, col_err, oob_err and all internal pipeline registers go to 0.
  - Memory contents are not reset.
  - Any read in flight is discarded: no dout_vld is produced for it.
  - A write presented in the same cycle as rst=1 still updates memory.
- Write: when we=1 and wa<DEPTH, each byte of M[wa] whose wbe bit is 1 takes the matching byte of di; bytes with wbe=0 are unchanged. If wbe is all zeros, memory is unchanged.
- Read, OUT_REG=0:
  - re=1 at edge N: the stage-1 register captures the read word and dout_vld=1 during cycle N+1.
  - dout follows the stage-1 register.
- Read, OUT_REG=1: stage-1 data moves to a second register at edge N+1; dout and dout_vld appear during cycle N+2.
- Back-to-back reads on consecutive cycles give a dout_vld on consecutive cycles with full throughput.
- dout holds its last value when no read completes; it is not cleared when dout_vld=0.
- Same-address collision (re=1, we=1, ra==wa, address < DEPTH):
  - BYPASS=1: the read word is the old M[ra] with the bytes enabled by wbe replaced by di.
  - BYPASS=0: the read word is the old M[ra], and col_err is set at that edge.
- Different-address read and write in the same cycle are independent.
- Out-of-range (address >= DEPTH; only possible when DEPTH < 2**AW):
  - Write: dropped, memory unchanged, oob_err set.
  - Read: still produces dout_vld at the normal latency with dout=0; oob_err set.
- col_err and oob_err are cleared only by rst.
- Parameter checks: elaboration-time error if WIDTH%8 != 0 or 2**AW < DEPTH.

Test Plan:
- Reset and latency:
  - Apply rst, then write 0xA5..A5 to address 3.
  - Read address 3 with OUT_REG=0: dout_vld=1 and dout=0xA5..A5 exactly one cycle after re.
  - Same read with OUT_REG=1: dout_vld and data two cycles after re.
  - All outputs are 0 after reset.
- Byte enables:
  - Write all-ones to address 5, then write di=0 with wbe=0x0001.
  - Reading address 5 returns all-ones except byte 0 = 0x00.
  - A write with wbe=0 leaves the word unchanged.
- Collision:
  - Address 7 holds 0x11..11; in one cycle write 0x22..22 to address 7 (wbe all ones) and read address 7.
  - BYPASS=1: dout=0x22..22 and col_err=0.
  - BYPASS=0: dout=0x11..11 and col_err=1, staying 1 until rst.
- Streaming:
  - Issue reads of addresses 0..9 on consecutive cycles.
  - Ten consecutive dout_vld pulses return the words in order; dout holds the last word afterwards.
- Out-of-range (DEPTH=100, AW=7):
  - Write address 120: oob_err=1 and memory unchanged.
  - Read address 120: dout_vld=1 with dout=0.
- Reset mid-operation:
  - With OUT_REG=1, assert rst one cycle after re.
  - No dout_vld is produced for that read; dout=0; memory contents are preserved, so a later read of the same address returns the old data.
